// File: rtl/ft600_dev_model_if.sv
// FT600 245 synchronous FIFO bus, chip side vs FPGA master side.
// Tristate data/byte-enable lines are carried as split in/out/oe signals.
interface ft600_dev_model_if #(
    parameter int FT_DATA_WIDTH = 32
);
    logic                     rxf_n;
    logic                     txe_n;
    logic                     rd_n;
    logic                     oe_n;
    logic                     wr_n;
    logic [FT_DATA_WIDTH-1:0] ft_data_i;
    logic [FT_DATA_WIDTH-1:0] ft_data_o;
    logic                     ft_data_oe;
    logic [3:0]               ft_be_i;
    logic [3:0]               ft_be_o;

    modport master (
        input  rxf_n,
        input  txe_n,
        input  ft_data_o,
        input  ft_data_oe,
        input  ft_be_o,
        output rd_n,
        output oe_n,
        output wr_n,
        output ft_data_i,
        output ft_be_i
    );

    modport slave (
        output rxf_n,
        output txe_n,
        output ft_data_o,
        output ft_data_oe,
        output ft_be_o,
        input  rd_n,
        input  oe_n,
        input  wr_n,
        input  ft_data_i,
        input  ft_be_i
    );
endinterface

// File: rtl/ft600_dev_model.sv
// FT600 chip-side responder: RX FIFO (host->FPGA) and TX FIFO (FPGA->host)
// behind the 245 synchronous FIFO bus, with a stream port for the host.
module ft600_dev_model #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int DEPTH_LOG2    = 6,
    parameter int TX_MARGIN     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ft600_dev_model_if.slave         bus,
    input  logic                     usb_in_valid,
    input  logic [FT_DATA_WIDTH-1:0] usb_in_data,
    output logic                     usb_in_ready,
    output logic                     usb_out_valid,
    output logic [FT_DATA_WIDTH-1:0] usb_out_data,
    output logic [3:0]               usb_out_be,
    input  logic                     usb_out_ready,
    output logic [DEPTH_LOG2:0]      rx_level,
    output logic [DEPTH_LOG2:0]      tx_level,
    output logic                     rx_underrun,
    output logic                     tx_overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int TW    = FT_DATA_WIDTH + 4;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [LW-1:0]         LVL_ONE    = LW'(1);
    localparam logic [LW-1:0]         LVL_DEPTH  = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_MARGIN = LW'(TX_MARGIN);

    logic [FT_DATA_WIDTH-1:0] r_rx_mem [DEPTH];
    logic [TW-1:0]            r_tx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] r_rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rx_rd_ptr;
    logic [LW-1:0]         r_rx_level;
    logic [DEPTH_LOG2-1:0] r_tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_tx_rd_ptr;
    logic [LW-1:0]         r_tx_level;

    logic r_rxf_n;
    logic r_txe_n;
    logic r_ft_data_oe;
    logic r_rx_underrun;
    logic r_tx_overflow;

    logic          w_rd_req;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_wr_req;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic [LW-1:0] w_rx_level_nxt;
    logic [LW-1:0] w_tx_level_nxt;
    logic [LW-1:0] w_tx_free_nxt;
    logic [TW-1:0] w_tx_head;

    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_full  = (r_rx_level == LVL_DEPTH);
    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_full  = (r_tx_level == LVL_DEPTH);

    // Bus-side read request; a pop only happens while rxf_n advertises data.
    assign w_rd_req  = ~bus.oe_n & ~bus.rd_n;
    assign w_rx_pop  = w_rd_req & ~r_rxf_n;
    assign w_rx_push = usb_in_valid & usb_in_ready;

    // Writes are ignored while the model owns the bus (oe_n low).
    // Above the margin writes are still taken until the FIFO is truly full.
    assign w_wr_req  = ~bus.wr_n & bus.oe_n;
    assign w_tx_push = w_wr_req & ~w_tx_full;
    assign w_tx_pop  = usb_out_valid & usb_out_ready;

    assign w_rx_level_nxt = r_rx_level
                          + (w_rx_push ? LVL_ONE : '0)
                          - (w_rx_pop  ? LVL_ONE : '0);
    assign w_tx_level_nxt = r_tx_level
                          + (w_tx_push ? LVL_ONE : '0)
                          - (w_tx_pop  ? LVL_ONE : '0);
    assign w_tx_free_nxt  = LVL_DEPTH - w_tx_level_nxt;

    assign w_tx_head = r_tx_mem[r_tx_rd_ptr];

    // Head word is presented combinationally; forced to zero when empty
    // so stale memory never shows on the bus.
    assign bus.ft_data_o  = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
    assign bus.ft_be_o    = 4'b1111;
    assign bus.ft_data_oe = r_ft_data_oe;
    assign bus.rxf_n      = r_rxf_n;
    assign bus.txe_n      = r_txe_n;

    assign usb_in_ready  = ~w_rx_full;
    assign usb_out_valid = ~w_tx_empty;
    assign usb_out_data  = w_tx_head[FT_DATA_WIDTH-1:0];
    assign usb_out_be    = w_tx_head[TW-1:FT_DATA_WIDTH];

    assign rx_level    = r_rx_level;
    assign tx_level    = r_tx_level;
    assign rx_underrun = r_rx_underrun;
    assign tx_overflow = r_tx_overflow;

    // FIFO storage; contents need no reset since levels gate visibility.
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= usb_in_data;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= {bus.ft_be_i, bus.ft_data_i};
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_level  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            end
            r_rx_level <= w_rx_level_nxt;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_level  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
            end
            r_tx_level <= w_tx_level_nxt;
        end
    end

    // Bus flags from next-state levels, plus one-cycle bus turnaround.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxf_n      <= 1'b1;
            r_txe_n      <= 1'b1;
            r_ft_data_oe <= 1'b0;
        end else begin
            r_rxf_n      <= (w_rx_level_nxt == '0);
            r_txe_n      <= (w_tx_free_nxt <= LVL_MARGIN);
            r_ft_data_oe <= ~bus.oe_n;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_underrun <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_rd_req & r_rxf_n) begin
                r_rx_underrun <= 1'b1;
            end
            if (w_wr_req & w_tx_full) begin
                r_tx_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ft600_dev_model.sv
// Self-checking bench for ft600_dev_model: table vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_ft600_dev_model;
    localparam int W      = 32;
    localparam int DL     = 6;
    localparam int DEPTH  = 64;
    localparam int MARGIN = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          usb_in_valid;
    logic [W-1:0]  usb_in_data;
    logic          usb_in_ready;
    logic          usb_out_valid;
    logic [W-1:0]  usb_out_data;
    logic [3:0]    usb_out_be;
    logic          usb_out_ready;
    logic [DL:0]   rx_level;
    logic [DL:0]   tx_level;
    logic          rx_underrun;
    logic          tx_overflow;

    ft600_dev_model_if #(.FT_DATA_WIDTH(W)) bus ();

    ft600_dev_model #(
        .FT_DATA_WIDTH(W),
        .DEPTH_LOG2   (DL),
        .TX_MARGIN    (MARGIN)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .usb_in_valid (usb_in_valid),
        .usb_in_data  (usb_in_data),
        .usb_in_ready (usb_in_ready),
        .usb_out_valid(usb_out_valid),
        .usb_out_data (usb_out_data),
        .usb_out_be   (usb_out_be),
        .usb_out_ready(usb_out_ready),
        .rx_level     (rx_level),
        .tx_level     (tx_level),
        .rx_underrun  (rx_underrun),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   rx_q [$];
    logic [W+3:0]   tx_q [$];
    bit             m_und;
    bit             m_ovf;
    bit             m_rxf;
    bit             m_txe;
    bit             m_oe;

    typedef struct {
        logic        oe_n;
        logic        rd_n;
        logic        in_v;
        logic [31:0] in_d;
        logic [6:0]  e_rxl;
        logic        e_rxf;
        logic        e_txe;
        logic        e_oe;
        logic        e_und;
        logic [31:0] e_do;
    } vec_t;

    vec_t tv [11];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.oe_n      = 1'b1;
        bus.rd_n      = 1'b1;
        bus.wr_n      = 1'b1;
        bus.ft_data_i = '0;
        bus.ft_be_i   = 4'hF;
        usb_in_valid  = 1'b0;
        usb_in_data   = '0;
        usb_out_ready = 1'b0;
    endtask

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_und = 0;
        m_ovf = 0;
        m_rxf = 1;
        m_txe = 1;
        m_oe  = 0;
    endtask

    // Advance the reference model by one edge using the applied inputs.
    task automatic model_edge();
        bit rd_req;
        bit rx_pop;
        bit rx_push;
        bit wr_req;
        bit tx_full;
        bit tx_pop;
        rd_req  = !bus.oe_n && !bus.rd_n;
        rx_pop  = rd_req && rx_q.size() > 0;
        rx_push = usb_in_valid && rx_q.size() < DEPTH;
        wr_req  = !bus.wr_n && bus.oe_n;
        tx_full = tx_q.size() == DEPTH;
        tx_pop  = usb_out_ready && tx_q.size() > 0;
        if (rd_req && rx_q.size() == 0) m_und = 1;
        if (wr_req && tx_full) m_ovf = 1;
        if (rx_pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(usb_in_data);
        if (tx_pop) void'(tx_q.pop_front());
        if (wr_req && !tx_full) tx_q.push_back({bus.ft_be_i, bus.ft_data_i});
        m_rxf = rx_q.size() == 0;
        m_txe = (DEPTH - tx_q.size()) <= MARGIN;
        m_oe  = !bus.oe_n;
    endtask

    task automatic compare_all();
        logic [W-1:0] e_do;
        e_do = '0;
        if (rx_q.size() > 0) e_do = rx_q[0];
        chk("rxf_n", bus.rxf_n, m_rxf);
        chk("txe_n", bus.txe_n, m_txe);
        chk("data_oe", bus.ft_data_oe, m_oe);
        chk("data_o", bus.ft_data_o, e_do);
        chk("be_o", bus.ft_be_o, 4'hF);
        chk("rx_level", rx_level, rx_q.size());
        chk("tx_level", tx_level, tx_q.size());
        chk("in_ready", usb_in_ready, rx_q.size() < DEPTH);
        chk("out_valid", usb_out_valid, tx_q.size() > 0);
        if (tx_q.size() > 0) begin
            chk("out_data", usb_out_data, tx_q[0][W-1:0]);
            chk("out_be", usb_out_be, tx_q[0][W+3:W]);
        end
        chk("underrun", rx_underrun, m_und);
        chk("overflow", tx_overflow, m_ovf);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_seq();
        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rxf", bus.rxf_n, 1'b1);
        chk("rst_txe", bus.txe_n, 1'b1);
        chk("rst_oe", bus.ft_data_oe, 1'b0);
        chk("rst_do", bus.ft_data_o, 32'h0);
        chk("rst_rxl", rx_level, 7'd0);
        chk("rst_txl", tx_level, 7'd0);
        chk("rst_und", rx_underrun, 1'b0);
        chk("rst_ovf", tx_overflow, 1'b0);
        reset_n = 1'b1;
        step();
        chk("post_txe", bus.txe_n, 1'b0);
        chk("post_rxf", bus.rxf_n, 1'b1);
    endtask

    task automatic run_table();
        for (int i = 0; i < 11; i++) begin
            bus.oe_n     = tv[i].oe_n;
            bus.rd_n     = tv[i].rd_n;
            usb_in_valid = tv[i].in_v;
            usb_in_data  = tv[i].in_d;
            step();
            chk($sformatf("tv%0d_rxl", i), rx_level, tv[i].e_rxl);
            chk($sformatf("tv%0d_rxf", i), bus.rxf_n, tv[i].e_rxf);
            chk($sformatf("tv%0d_txe", i), bus.txe_n, tv[i].e_txe);
            chk($sformatf("tv%0d_oe", i), bus.ft_data_oe, tv[i].e_oe);
            chk($sformatf("tv%0d_und", i), rx_underrun, tv[i].e_und);
            chk($sformatf("tv%0d_do", i), bus.ft_data_o, tv[i].e_do);
        end
        idle();
    endtask

    initial begin
        int nbe;
        int sent;
        int recv;
        int cyc;

        //         oe rd v  in_d          rxl rxf txe oe und do
        tv[0]  = '{1, 1, 1, 32'h11111111, 1, 0, 0, 0, 0, 32'h11111111};
        tv[1]  = '{1, 1, 1, 32'h11111102, 2, 0, 0, 0, 0, 32'h11111111};
        tv[2]  = '{1, 1, 1, 32'h11111103, 3, 0, 0, 0, 0, 32'h11111111};
        tv[3]  = '{1, 1, 1, 32'h11111104, 4, 0, 0, 0, 0, 32'h11111111};
        tv[4]  = '{0, 0, 0, 32'h0,        3, 0, 0, 1, 0, 32'h11111102};
        tv[5]  = '{0, 0, 0, 32'h0,        2, 0, 0, 1, 0, 32'h11111103};
        tv[6]  = '{0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 32'h11111104};
        tv[7]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 0, 32'h0};
        tv[8]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 1, 32'h0};
        tv[9]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 1, 32'h0};
        tv[10] = '{1, 0, 0, 32'h0,        0, 1, 0, 0, 1, 32'h0};

        idle();
        model_reset();

        // Scenarios 1 and 2: host push, master read, underrun.
        reset_seq();
        run_table();

        // Scenario 3: fill TX through the margin into overflow.
        bus.oe_n = 1'b1;
        bus.wr_n = 1'b0;
        for (int i = 1; i <= 65; i++) begin
            bus.ft_data_i = 32'hA000_0000 + i;
            bus.ft_be_i   = 4'hF;
            step();
            if (i == 61) chk("s3_txe61", bus.txe_n, 1'b0);
            if (i == 62) begin
                chk("s3_txe62", bus.txe_n, 1'b1);
                chk("s3_lvl62", tx_level, 7'd62);
            end
            if (i == 64) begin
                chk("s3_lvl64", tx_level, 7'd64);
                chk("s3_ovf64", tx_overflow, 1'b0);
            end
            if (i == 65) begin
                chk("s3_lvl65", tx_level, 7'd64);
                chk("s3_ovf65", tx_overflow, 1'b1);
            end
        end

        // Scenario 4: simultaneous push/pop holds the level at 62.
        bus.wr_n      = 1'b1;
        usb_out_ready = 1'b1;
        step();
        step();
        chk("s4_lvl", tx_level, 7'd62);
        bus.wr_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ft_data_i = 32'hB000_0000 + i;
            bus.ft_be_i   = (i == 4) ? 4'b0011 : 4'hF;
            step();
            chk("s4_hold", tx_level, 7'd62);
        end
        bus.wr_n = 1'b1;
        nbe = 0;
        for (int i = 0; i < 80; i++) begin
            if (!usb_out_valid) break;
            if (usb_out_be == 4'b0011) begin
                nbe++;
                chk("s4_be_word", usb_out_data, 32'hB000_0004);
            end
            step();
        end
        chk("s4_be_cnt", nbe, 1);
        chk("s4_empty", tx_level, 7'd0);
        idle();

        // Scenario 5: 200 words streamed through RX with pointer wrap.
        reset_seq();
        bus.oe_n = 1'b0;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 200 || rx_q.size() > 0) && cyc < 3000) begin
            usb_in_valid = (sent < 200);
            usb_in_data  = 32'hC000_0000 + sent;
            bus.rd_n = !(rx_q.size() > 0 && $urandom_range(0, 2) != 0);
            if (!bus.rd_n) begin
                chk("s5_order", bus.ft_data_o, 32'hC000_0000 + recv);
                recv++;
            end
            if (usb_in_valid && rx_q.size() < DEPTH) sent++;
            chk("s5_max", rx_level <= 7'd64, 1'b1);
            step();
            cyc++;
        end
        chk("s5_recv", recv, 200);
        chk("s5_und", rx_underrun, 1'b0);
        idle();

        // Randomized mixed traffic on both FIFOs.
        for (int i = 0; i < 400; i++) begin
            bus.oe_n      = ($urandom_range(0, 3) == 0);
            bus.rd_n      = $urandom_range(0, 1);
            bus.wr_n      = $urandom_range(0, 1);
            bus.ft_data_i = $urandom;
            bus.ft_be_i   = 4'($urandom);
            usb_in_valid  = $urandom_range(0, 1);
            usb_in_data   = $urandom;
            usb_out_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();

        // Scenario 6: asynchronous reset mid-burst.
        reset_seq();
        for (int i = 0; i < 10; i++) begin
            usb_in_valid  = 1'b1;
            usb_in_data   = 32'hD000_0000 + i;
            bus.wr_n      = (i < 5) ? 1'b0 : 1'b1;
            bus.ft_data_i = 32'hE000_0000 + i;
            step();
        end
        idle();
        bus.oe_n = 1'b0;
        step();
        chk("s6_rxl", rx_level, 7'd10);
        chk("s6_txl", tx_level, 7'd5);
        chk("s6_oe", bus.ft_data_oe, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6_rxl0", rx_level, 7'd0);
        chk("s6_txl0", tx_level, 7'd0);
        chk("s6_rxf", bus.rxf_n, 1'b1);
        chk("s6_txe", bus.txe_n, 1'b1);
        chk("s6_oe0", bus.ft_data_oe, 1'b0);
        chk("s6_do0", bus.ft_data_o, 32'h0);
        reset_seq();
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
